// File: rtl/cabac_sync_fifo_if.sv
// rtl/cabac_sync_fifo_if.sv - producer/consumer bundle for the CABAC synchronous FIFO
interface cabac_sync_fifo_if #(
    parameter int DATA_WIDTH = 76,
    parameter int ADDR_WIDTH = 3
);
    logic                  flush_i;
    logic                  wr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  rd_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  full_o;
    logic                  afull_o;
    logic                  empty_o;
    logic [ADDR_WIDTH:0]   count_o;
    logic                  ovf_o;

    // Side that drives requests and watches status (producer + consumer).
    modport master (
        output flush_i, wr_i, data_i, rd_i,
        input  data_o, valid_o, full_o, afull_o, empty_o, count_o, ovf_o
    );

    // The FIFO itself.
    modport slave (
        input  flush_i, wr_i, data_i, rd_i,
        output data_o, valid_o, full_o, afull_o, empty_o, count_o, ovf_o
    );
endinterface

// File: rtl/cabac_sync_fifo.sv
// rtl/cabac_sync_fifo.sv - single-clock first-word-fall-through FIFO feeding CABAC binarization
module cabac_sync_fifo #(
    parameter int DATA_WIDTH = 76,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_TH   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    cabac_sync_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  wr_en;
    logic                  rd_en;

    // Status is purely a function of the registered pointers.
    always_comb begin
        count = wr_ptr - rd_ptr;
        empty = (count == '0);
        full  = (count == (ADDR_WIDTH + 1)'(DEPTH));
        // A full FIFO drops the write even if a pop frees a slot this cycle;
        // flush overrides both sides.
        wr_en = bus.wr_i & ~full & ~bus.flush_i;
        rd_en = bus.rd_i & ~empty & ~bus.flush_i;
    end

    // Pointer update: flush wins, otherwise advance on accepted write/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky overflow: any write attempt while full, cleared only by flush or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ovf_o <= 1'b0;
        end else if (bus.flush_i) begin
            bus.ovf_o <= 1'b0;
        end else if (bus.wr_i && full) begin
            bus.ovf_o <= 1'b1;
        end
    end

    // Storage is left unreset; stale words never reach data_o because it is gated by valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_i;
    end

    // Head word falls through with no same-cycle write bypass.
    always_comb begin
        bus.count_o = count;
        bus.empty_o = empty;
        bus.full_o  = full;
        bus.afull_o = (count >= (ADDR_WIDTH + 1)'(AFULL_TH));
        bus.valid_o = ~empty;
        bus.data_o  = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
endmodule

// File: tb/tb_cabac_sync_fifo.sv
// tb/tb_cabac_sync_fifo.sv - scoreboard bench for cabac_sync_fifo
module tb_cabac_sync_fifo;
    localparam int DW    = 76;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int ATH   = 6;

    logic clk;
    logic rst_n;

    cabac_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cabac_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(ATH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_q [$];
    int            mcount;
    logic          movf;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT will perform at the next edge is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid_o && bus.rd_i && !bus.flush_i) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 128'(bus.data_o), 128'(0));
                    chk("pop_unexpected_valid", 128'(bus.valid_o), 128'(0));
                end else begin
                    chk("pop_data", 128'(bus.data_o), 128'(exp_q.pop_front()));
                end
            end else if (!bus.valid_o) begin
                chk("idle_data_zero", 128'(bus.data_o), 128'(0));
            end
        end
    end

    task automatic check_status(input string tag);
        chk({tag, "_count"}, 128'(bus.count_o), 128'(mcount));
        chk({tag, "_empty"}, 128'(bus.empty_o), 128'(mcount == 0));
        chk({tag, "_full"},  128'(bus.full_o),  128'(mcount == DEPTH));
        chk({tag, "_afull"}, 128'(bus.afull_o), 128'(mcount >= ATH));
        chk({tag, "_valid"}, 128'(bus.valid_o), 128'(mcount != 0));
        chk({tag, "_ovf"},   128'(bus.ovf_o),   128'(movf));
    endtask

    // One clock of stimulus, entered and left at posedge+1.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f,
                        input string tag);
        logic acc_w, acc_r, ovf_set;
        bus.wr_i    = w;
        bus.data_i  = d;
        bus.rd_i    = r;
        bus.flush_i = f;
        acc_w   = w && !f && (mcount < DEPTH);
        acc_r   = r && !f && (mcount > 0);
        ovf_set = w && !f && (mcount == DEPTH);
        @(posedge clk);
        #1;
        if (f) begin
            mcount = 0;
            movf   = 1'b0;
            exp_q.delete();
        end else begin
            if (acc_w) exp_q.push_back(d);
            mcount = mcount + int'(acc_w) - int'(acc_r);
            if (ovf_set) movf = 1'b1;
        end
        bus.wr_i    = 1'b0;
        bus.rd_i    = 1'b0;
        bus.flush_i = 1'b0;
        check_status(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.wr_i    = 1'b0;
        bus.rd_i    = 1'b0;
        bus.flush_i = 1'b0;
        bus.data_i  = '0;
        mcount      = 0;
        movf        = 1'b0;
        #12;
        chk("reset_count", 128'(bus.count_o), 128'(0));
        chk("reset_empty", 128'(bus.empty_o), 128'(1));
        chk("reset_valid", 128'(bus.valid_o), 128'(0));
        chk("reset_data",  128'(bus.data_o),  128'(0));
        chk("reset_afull", 128'(bus.afull_o), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full with 1..8, then a dropped 9th write.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0, "fill");
            chk("fill_count_literal", 128'(bus.count_o), 128'(i));
            chk("fill_afull_literal", 128'(bus.afull_o), 128'(i >= 6));
        end
        chk("full_literal", 128'(bus.full_o), 128'(1));
        step(1'b1, DW'('h99), 1'b0, 1'b0, "ovf_write");
        chk("ovf_literal", 128'(bus.ovf_o), 128'(1));
        chk("ovf_count_literal", 128'(bus.count_o), 128'(8));

        // Drain in order; monitor checks 1..8.
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");
        chk("drain_empty_literal", 128'(bus.empty_o), 128'(1));
        chk("drain_data_literal",  128'(bus.data_o),  128'(0));

        // Pop on empty is ignored.
        step(1'b0, '0, 1'b1, 1'b0, "underflow");

        // Write to empty: no bypass in the write cycle, visible next cycle.
        bus.wr_i   = 1'b1;
        bus.data_i = DW'('hABC);
        #3;
        chk("wr_empty_sameCycle_valid", 128'(bus.valid_o), 128'(0));
        @(posedge clk);
        #1;
        bus.wr_i = 1'b0;
        exp_q.push_back(DW'('hABC));
        mcount = 1;
        chk("wr_empty_next_valid", 128'(bus.valid_o), 128'(1));
        chk("wr_empty_next_data",  128'(bus.data_o),  128'('hABC));
        step(1'b0, '0, 1'b1, 1'b0, "pop_abc");

        // Hold occupancy at 3 with simultaneous write+pop, crossing the pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, DW'('h100 + i), 1'b0, 1'b0, "pre3");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'('h200 + i), 1'b1, 1'b0, "steady3");
            chk("steady3_count_literal", 128'(bus.count_o), 128'(3));
        end

        // Fill, then write+pop while full: pop happens, write is dropped, ovf sets.
        for (int i = 0; i < 5; i++) step(1'b1, DW'('h300 + i), 1'b0, 1'b0, "refill");
        step(1'b1, DW'('hDEAD), 1'b1, 1'b0, "full_wr_pop");
        chk("full_wr_pop_count_literal", 128'(bus.count_o), 128'(7));
        chk("full_wr_pop_ovf_literal",   128'(bus.ovf_o),   128'(1));

        // Flush with ovf set and a concurrent write.
        step(1'b1, DW'('hBEEF), 1'b0, 1'b1, "flush");
        chk("flush_count_literal", 128'(bus.count_o), 128'(0));
        chk("flush_ovf_literal",   128'(bus.ovf_o),   128'(0));
        chk("flush_data_literal",  128'(bus.data_o),  128'(0));

        // Asynchronous reset mid-burst at occupancy 5.
        for (int i = 0; i < 5; i++) step(1'b1, DW'('h400 + i), 1'b0, 1'b0, "preburst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 128'(bus.count_o), 128'(0));
        chk("async_rst_empty", 128'(bus.empty_o), 128'(1));
        chk("async_rst_data",  128'(bus.data_o),  128'(0));
        exp_q.delete();
        mcount = 0;
        movf   = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, DW'('h555), 1'b0, 1'b0, "post_rst_wr");
        chk("post_rst_head", 128'(bus.data_o), 128'('h555));
        step(1'b0, '0, 1'b1, 1'b0, "post_rst_pop");

        @(posedge clk);
        #1;
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cabac_sync_fifo.md
CABAC_SYNC_FIFO -- requirements
Module: cabac_sync_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 76, the word width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 3, giving DEPTH = 2^ADDR_WIDTH words; legal range 1..8.
REQ-003 SHALL provide parameter AFULL_TH, default 6, the almost-full occupancy threshold; legal range 1..DEPTH.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL provide port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL provide port flush_i, input, 1 bit: synchronous clear of contents.
REQ-007 SHALL provide port wr_i, input, 1 bit: write request.
REQ-008 SHALL provide port data_i, input, DATA_WIDTH bits: write data.
REQ-009 SHALL provide port rd_i, input, 1 bit: consumer ready (binarization accept).
REQ-010 SHALL provide port data_o, output, DATA_WIDTH bits: head word.
REQ-011 SHALL provide port valid_o, output, 1 bit: head word valid.
REQ-012 SHALL provide port full_o, output, 1 bit: no free entry.
REQ-013 SHALL provide port afull_o, output, 1 bit: occupancy is at least AFULL_TH.
REQ-014 SHALL provide port empty_o, output, 1 bit: no stored entry.
REQ-015 SHALL provide port count_o, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH.
REQ-016 SHALL provide port ovf_o, output, 1 bit: sticky overflow flag (write attempted while full).

Function
REQ-017 SHALL hold read and write pointers of ADDR_WIDTH+1 bits each; the MSB is the wrap bit.
REQ-018 SHALL accept a write when wr_i=1 and full_o=0, storing data_i at wr_ptr and incrementing wr_ptr modulo 2^(ADDR_WIDTH+1).
REQ-019 SHALL pop the head word when valid_o=1 and rd_i=1, incrementing rd_ptr modulo 2^(ADDR_WIDTH+1).
REQ-020 SHALL derive outputs combinationally from the registered pointers: count_o = wr_ptr - rd_ptr; empty_o = (count_o==0); full_o = (count_o==DEPTH); afull_o = (count_o>=AFULL_TH).
REQ-021 SHALL present data_o first-word-fall-through: data_o = mem[rd_ptr] with valid_o = ~empty_o, and data_o = 0 whenever valid_o = 0.
REQ-022 SHALL make a word written in cycle N visible on data_o/valid_o in cycle N+1; there is no same-cycle write-to-read bypass.
REQ-023 SHALL, on a simultaneous accepted write and pop, perform both and leave count_o unchanged.
REQ-024 SHALL drop a write while full_o=1, even if a pop occurs in the same cycle, and set ovf_o=1 on the following edge.
REQ-025 SHALL ignore rd_i while empty_o=1: no pointer change and no underflow.
REQ-026 SHALL, with flush_i=1, set both pointers to 0 and clear ovf_o at the next edge; wr_i and rd_i are ignored in that cycle, and flush_i has priority over all other operations.
REQ-027 SHALL wrap pointers seamlessly, so that continuous operation across the 2^(ADDR_WIDTH+1) pointer boundary preserves FIFO order.
REQ-028 SHALL leave memory contents unreset; they are unobservable because data_o is forced to 0 when the FIFO is empty.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously clear pointers and ovf_o, giving count_o=0, empty_o=1, full_o=0, afull_o=0, valid_o=0, data_o=0.
REQ-030 SHALL, on reset asserted mid-operation, discard all stored words; the first write after rst_n rises is the first word read.

Verification
REQ-031 SHALL cover fill to full: write 0x1..0x8 with rd_i=0 -> count_o steps 1..8; afull_o rises at count_o=6; full_o=1 at 8; a 9th write is dropped and ovf_o=1.
REQ-032 SHALL cover drain in order: from full, rd_i=1 -> data_o reads 0x1..0x8 on consecutive cycles; empty_o=1 and data_o=0 after the 8th pop.
REQ-033 SHALL cover simultaneous write and pop at count_o=3 for 20 cycles -> count_o holds at 3, pointers wrap past 15, and the output sequence matches the input.
REQ-034 SHALL cover write to empty: write 0xABC in cycle N -> valid_o=0 in N and valid_o=1 with data_o=0xABC in N+1.
REQ-035 SHALL cover flush with ovf set and wr_i=1 in the same cycle -> next cycle count_o=0, ovf_o=0, and the concurrent write is discarded.
REQ-036 SHALL cover async reset mid-burst at count_o=5 -> outputs immediately take reset values (count_o=0, empty_o=1, data_o=0), without waiting for a clock edge.
